// File: rtl/parity_load_seq.sv
// Parity-load sequencer: start launches a burst of len one-hot load strobes on a latched channel.
// Optional one-deep pending start slot is enabled by defining PARITY_LOAD_PEND_EN.
module parity_load_seq #(
   parameter int NCH   = 4,
   parameter int CH_W  = 2,
   parameter int LEN_W = 4
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [CH_W-1:0]  ch_sel,
   input  logic             stall,
   input  logic             abort,
   output logic [NCH-1:0]   p_en,
   output logic [LEN_W-1:0] p_idx,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      LOAD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [LEN_W-1:0] len_reg, len_next;
   logic [LEN_W-1:0] idx_reg, idx_next;
   logic [CH_W-1:0]  ch_reg, ch_next;
   logic [CH_W-1:0]  ch_clamped;
   logic             last_word;
   logic             strobe;

`ifdef PARITY_LOAD_PEND_EN
   logic             pend_valid_reg, pend_valid_next;
   logic [LEN_W-1:0] pend_len_reg, pend_len_next;
   logic [CH_W-1:0]  pend_ch_reg, pend_ch_next;
`endif

   // Out-of-range channel requests fold onto the top channel.
   always_comb begin
      ch_clamped = ch_sel;
      if (int'(ch_sel) >= NCH)
         ch_clamped = CH_W'(NCH - 1);
   end

   assign last_word = (idx_reg == (len_reg - LEN_W'(1)));
   assign strobe    = (state_reg == LOAD) && !stall && !abort;

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_pen
         assign p_en[gi] = strobe && (ch_reg == CH_W'(gi));
      end
   endgenerate

   assign p_idx = idx_reg;
   assign busy  = (state_reg == ARM) || (state_reg == LOAD);
   assign done  = (state_reg == DONE);

   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      ch_next    = ch_reg;
      idx_next   = idx_reg;
`ifdef PARITY_LOAD_PEND_EN
      pend_valid_next = pend_valid_reg;
      pend_len_next   = pend_len_reg;
      pend_ch_next    = pend_ch_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               len_next   = len;
               ch_next    = ch_clamped;
               idx_next   = '0;
               state_next = ARM;
            end
         end
         ARM: begin
            if (abort || (len_reg == '0))
               state_next = DONE;
            else
               state_next = LOAD;
         end
         LOAD: begin
            if (abort) begin
               idx_next   = '0;
               state_next = DONE;
            end else if (!stall) begin
               if (last_word) begin
                  idx_next   = '0;
                  state_next = DONE;
               end else begin
                  idx_next = idx_reg + LEN_W'(1);
               end
            end
         end
         default: begin
            idx_next   = '0;
            state_next = IDLE;
`ifdef PARITY_LOAD_PEND_EN
            // A start arriving in this very cycle is the newest request and wins over the slot.
            if (start) begin
               len_next        = len;
               ch_next         = ch_clamped;
               pend_valid_next = 1'b0;
               state_next      = ARM;
            end else if (pend_valid_reg) begin
               len_next        = pend_len_reg;
               ch_next         = pend_ch_reg;
               pend_valid_next = 1'b0;
               state_next      = ARM;
            end
`endif
         end
      endcase
`ifdef PARITY_LOAD_PEND_EN
      if ((state_reg == ARM) || (state_reg == LOAD)) begin
         if (abort) begin
            pend_valid_next = 1'b0;
         end else if (start) begin
            pend_valid_next = 1'b1;
            pend_len_next   = len;
            pend_ch_next    = ch_clamped;
         end
      end
`endif
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_reg <= IDLE;
         len_reg   <= '0;
         ch_reg    <= '0;
         idx_reg   <= '0;
`ifdef PARITY_LOAD_PEND_EN
         pend_valid_reg <= 1'b0;
         pend_len_reg   <= '0;
         pend_ch_reg    <= '0;
`endif
      end else begin
         state_reg <= state_next;
         len_reg   <= len_next;
         ch_reg    <= ch_next;
         idx_reg   <= idx_next;
`ifdef PARITY_LOAD_PEND_EN
         pend_valid_reg <= pend_valid_next;
         pend_len_reg   <= pend_len_next;
         pend_ch_reg    <= pend_ch_next;
`endif
      end
   end

endmodule
